// File: rtl/mem_ram_arbiter.sv
// ---------------------------------------------------------------------------
// mem_ram_arbiter
//
// Purpose:
//   Lets two independent requesters share one single-port synchronous RAM.
//   Transactions are granted round-robin, serialised through a four-state
//   sequencer (IDLE -> ISSUE -> [WAIT] -> DONE -> IDLE), and each one ends
//   with a single-cycle acknowledge to the requesting port. Every output is
//   driven straight from a register.
//
// Parameters:
//   ADDR_W  RAM address width (depth 2**ADDR_W)
//   DATA_W  RAM data width
//   RD_LAT  RAM read latency in cycles, legal range 1..4. It is counted from
//           the edge that samples ram_read_rq to the edge at which
//           ram_read_data may be captured.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   p0_* / p1_*        requester ports: req (held until ack), we (1=write),
//                      addr, wdata in; ack (1-cycle pulse), rdata out
//   ram_read_rq        one-cycle read strobe to the RAM
//   ram_write_rq       one-cycle write strobe to the RAM
//   ram_address        RAM address, held until the next grant
//   ram_write_data     RAM write data, held until the next grant
//   ram_read_data      RAM read data input
//   busy               high whenever the sequencer is not in IDLE
//   grant_id           port that owns the current (or last) transaction
// ---------------------------------------------------------------------------
module mem_ram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,

  output logic              ram_read_rq,
  output logic              ram_write_rq,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data,

  output logic              busy,
  output logic              grant_id
);

  // Wide enough for RD_LAT-1 with RD_LAT up to 4.
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_rr;        // 0: port 0 wins a tie, 1: port 1 wins
  logic                r_we;        // granted transaction is a write
  logic                r_gnt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rd_rq;
  logic                r_wr_rq;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ack0;
  logic                r_ack1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                r_busy;

  logic                w_req_any;
  logic                w_sel;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  // Arbitration: a lone requester always wins; on a tie the round-robin
  // pointer decides.
  assign w_req_any   = p0_req | p1_req;
  assign w_sel       = (p0_req & p1_req) ? r_rr : p1_req;
  assign w_sel_we    = w_sel ? p1_we    : p0_we;
  assign w_sel_addr  = w_sel ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_sel ? p1_wdata : p0_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_rr     <= 1'b0;
      r_we     <= 1'b0;
      r_gnt    <= 1'b0;
      r_cnt    <= '0;
      r_rd_rq  <= 1'b0;
      r_wr_rq  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            // Attributes are captured here; later changes on either port
            // have no effect until the next grant.
            r_gnt   <= w_sel;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_wr_rq <= w_sel_we;
            r_rd_rq <= ~w_sel_we;
            // Pointer flips on every grant, contested or not.
            r_rr    <= ~w_sel;
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          r_rd_rq <= 1'b0;
          r_wr_rq <= 1'b0;
          if (r_we) begin
            if (r_gnt) begin
              r_ack1 <= 1'b1;
            end else begin
              r_ack0 <= 1'b1;
            end
            r_state <= ST_DONE;
          end else begin
            r_cnt   <= CNT_W'(RD_LAT - 1);
            r_state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (r_cnt == '0) begin
            // Only the owning port's rdata moves; the other keeps its value.
            if (r_gnt) begin
              r_rdata1 <= ram_read_data;
              r_ack1   <= 1'b1;
            end else begin
              r_rdata0 <= ram_read_data;
              r_ack0   <= 1'b1;
            end
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_DONE: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign p0_ack         = r_ack0;
  assign p1_ack         = r_ack1;
  assign p0_rdata       = r_rdata0;
  assign p1_rdata       = r_rdata1;
  assign ram_read_rq    = r_rd_rq;
  assign ram_write_rq   = r_wr_rq;
  assign ram_address    = r_addr;
  assign ram_write_data = r_wdata;
  assign busy           = r_busy;
  assign grant_id       = r_gnt;

endmodule

// File: doc/mem_ram_arbiter.md
Name: mem_ram_arbiter

Overview:
Two-port round-robin arbiter and sequencer for the single-port synchronous RAM `mem_ram_sync` (64x8). It lets two independent requesters (port 0, port 1) share the RAM. It serialises their read/write transactions and generates the RAM `read_rq`/`write_rq` strobes. Read data is returned with a one-cycle acknowledge pulse per transaction.

Parameters:
ADDR_W, 6, RAM address width (depth 2**ADDR_W)
DATA_W, 8, RAM data width
RD_LAT, 1, RAM read latency in cycles from the strobe-sampling edge to the edge at which `read_data` is valid (legal values 1..4)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
p0_req  input  1  port 0 transaction request, held until p0_ack
p0_we  input  1  port 0: 1=write, 0=read
p0_addr  input  ADDR_W  port 0 address
p0_wdata  input  DATA_W  port 0 write data
p0_ack  output  1  port 0 one-cycle completion pulse
p0_rdata  output  DATA_W  port 0 read data, valid while p0_ack=1 and held afterwards
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same as port 0, for port 1
ram_read_rq  output  1  to RAM read_rq
ram_write_rq  output  1  to RAM write_rq
ram_address  output  ADDR_W  to RAM rw_address
ram_write_data  output  DATA_W  to RAM write_data
ram_read_data  input  DATA_W  from RAM read_data
busy  output  1  high in any state other than IDLE
grant_id  output  1  port owning the current or last transaction

Behaviour:
- All outputs are registered. Reset (rst=0, asynchronous) forces:
  - state=IDLE; ram_read_rq=0, ram_write_rq=0
  - ram_address=0, ram_write_data=0
  - p0_ack=0, p1_ack=0, p0_rdata=0, p1_rdata=0
  - busy=0, grant_id=0; RR pointer favours port 0.
- FSM states are IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Samples p0_req/p1_req at each edge.
  - If exactly one port is requesting, it is granted.
  - If both are requesting, the port favoured by the RR pointer is granted.
  - On grant: latch we/addr/wdata into ram_* registers, set grant_id, assert exactly one strobe (write -> ram_write_rq, read -> ram_read_rq), go to ISSUE.
  - The RR pointer then flips to favour the non-granted port. The pointer flips on every grant, contested or not.
- ISSUE: lasts exactly one cycle, with the strobe high.
  - Next edge: strobes -> 0.
  - A write goes to DONE with the granted port's ack=1.
  - A read goes to WAIT, with a cycle counter loaded to RD_LAT-1.
- WAIT:
  - Decrements the counter each cycle.
  - At the edge where the counter is 0, capture ram_read_data into the granted port's rdata, assert that port's ack, go to DONE.
- DONE: lasts exactly one cycle. Next edge: ack -> 0, state -> IDLE.
- Latency, with request sampled at edge k:
  - Write ack is high in the cycle after edge k+1.
  - Read ack is high in the cycle after edge k+1+RD_LAT (the cycle after k+2 for RD_LAT=1).
  - Minimum spacing between strobes is 3 cycles for writes and 3+RD_LAT cycles for reads. IDLE is always visited, so there is one idle cycle between transactions.
- ram_read_rq and ram_write_rq are never high together. Each is high for exactly one cycle per transaction.
- ram_address and ram_write_data hold their value after the transaction until the next grant.
- Request attributes (we/addr/wdata) are latched at grant. Changes on either port while busy are ignored.
- If req drops before ack, the transaction still completes and ack still pulses.
- The non-granted port's ack is never asserted. Its rdata is unchanged.
- pN_rdata updates only on that port's read completion. Writes leave it unchanged.
- Reset asserted mid-transaction aborts the transaction immediately: no ack and no further strobes. After rst is released, the FSM starts in IDLE with the pointer favouring port 0.
- A requester that sees ack at edge e must drop req or present a new request by edge e+1. It is re-sampled in IDLE at edge e+1.

Test Plan:
1. Reset with both req=1 -> all outputs 0. After rst release, the first grant goes to port 0 (grant_id=0). ram_write_rq pulses exactly 1 cycle.
2. p0 writes 0xA5 to addr 0x12; later p1 reads addr 0x12 (RAM model RD_LAT=1) -> p1_ack 2 cycles after the strobe-sampling edge, p1_rdata=0xA5, p0_rdata stays 0.
3. Both ports hold req continuously (p0 write, p1 read) for 8 transactions -> grants alternate 0,1,0,1,... Each strobe is separated by an idle cycle, and the strobes are never both high.
4. p0 changes p0_addr from 0x05 to 0x3F during ISSUE -> RAM sees 0x05 only, and the write lands at 0x05.
5. Drop rst during WAIT of a p1 read -> p1_ack never asserts and the strobes go to 0 immediately. After rst release, a p1-only request is granted normally.
6. With RD_LAT=3, a single p0 read of addr 0x3F -> ack 4 edges after the grant edge with the correct data. busy is high from the grant through DONE.
